// File: rtl/segment_counter_multi.sv
// N-digit BCD/hex up/down counter with prescaler, load/clear, wrap pulse and
// leading-zero-blanked 7-segment drive, one 9-bit field per digit.
module segment_counter_multi #(
  parameter int N_DIGITS = 2,
  parameter int CNT_NUM  = 12_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  hex_mode,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic                  blank_lz,
  output logic [4*N_DIGITS-1:0] count_val,
  output logic                  wrap,
  output logic [9*N_DIGITS-1:0] segment_led
);

  localparam int PW = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;
  localparam int CW = 4 * N_DIGITS;

  logic [PW-1:0]         r_presc;
  logic                  r_hex_q;
  logic                  r_hb;
  logic [CW-1:0]         r_count;
  logic                  r_wrap;
  logic [9*N_DIGITS-1:0] r_seg;

  logic                  w_tick;
  logic [CW-1:0]         w_step;
  logic [CW-1:0]         w_load;
  logic                  w_wrap;
  logic [9*N_DIGITS-1:0] w_seg;

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'h0: f_seg7 = 7'h3F;
      4'h1: f_seg7 = 7'h06;
      4'h2: f_seg7 = 7'h5B;
      4'h3: f_seg7 = 7'h4F;
      4'h4: f_seg7 = 7'h66;
      4'h5: f_seg7 = 7'h6D;
      4'h6: f_seg7 = 7'h7D;
      4'h7: f_seg7 = 7'h07;
      4'h8: f_seg7 = 7'h7F;
      4'h9: f_seg7 = 7'h6F;
      4'hA: f_seg7 = 7'h77;
      4'hB: f_seg7 = 7'h7C;
      4'hC: f_seg7 = 7'h39;
      4'hD: f_seg7 = 7'h5E;
      4'hE: f_seg7 = 7'h79;
      default: f_seg7 = 7'h71;
    endcase
  endfunction

  assign w_tick = en && (r_presc == PW'(CNT_NUM - 1));

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin : p_step
    logic       v_carry;
    logic [3:0] v_max;
    logic [3:0] v_d;
    logic [3:0] v_l;
    v_carry = 1'b1;
    v_max   = r_hex_q ? 4'hF : 4'h9;
    v_d     = '0;
    v_l     = '0;
    w_step  = r_count;
    w_load  = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      v_d = r_count[4*k +: 4];
      if (v_carry) begin
        if (up_dn) begin
          if (v_d == v_max) begin
            w_step[4*k +: 4] = '0;
          end else begin
            w_step[4*k +: 4] = v_d + 4'd1;
            v_carry = 1'b0;
          end
        end else begin
          if (v_d == 4'd0) begin
            w_step[4*k +: 4] = v_max;
          end else begin
            w_step[4*k +: 4] = v_d - 4'd1;
            v_carry = 1'b0;
          end
        end
      end
      v_l = load_val[4*k +: 4];
      w_load[4*k +: 4] = (!r_hex_q && (v_l > 4'd9)) ? 4'd9 : v_l;
    end
    w_wrap = v_carry;
  end

  // Scan from the most significant digit so blanking stops at the first nonzero digit.
  always_comb begin : p_disp
    logic        v_seen;
    logic        v_blank;
    logic [3:0]  v_d;
    int unsigned v_k;
    v_seen  = 1'b0;
    v_blank = 1'b0;
    v_d     = '0;
    v_k     = 0;
    w_seg   = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      v_k = N_DIGITS - 1 - i;
      v_d = r_count[4*v_k +: 4];
      if (v_d != 4'd0) v_seen = 1'b1;
      v_blank = blank_lz && !v_seen && (v_k != 0);
      w_seg[9*v_k +: 9] = v_blank ? 9'h100
                                  : {1'b0, (v_k == 0) ? r_hb : 1'b0, f_seg7(v_d)};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_presc <= '0;
      r_hex_q <= 1'b0;
      r_hb    <= 1'b0;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_seg   <= {N_DIGITS{9'h03F}};
    end else begin
      r_seg  <= w_seg;
      r_wrap <= 1'b0;
      if (hex_mode != r_hex_q) begin
        r_hex_q <= hex_mode;
        r_count <= '0;
        r_presc <= '0;
      end else if (clr) begin
        r_count <= '0;
        r_presc <= '0;
      end else if (load) begin
        r_count <= w_load;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_step;
        r_presc <= '0;
        r_hb    <= ~r_hb;
        r_wrap  <= w_wrap;
      end else if (en) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign count_val   = r_count;
  assign wrap        = r_wrap;
  assign segment_led = r_seg;

endmodule

// File: tb/tb_segment_counter_multi.sv
// Bench for segment_counter_multi (2 digits, 10-cycle prescaler): directed
// sequences, a constant vector table and a randomized run against an arithmetic model.
module tb_segment_counter_multi;

  localparam int ND  = 2;
  localparam int CNT = 10;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          hex_mode = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [4*ND-1:0] load_val = '0;
  logic          blank_lz = 1'b0;
  logic [4*ND-1:0] count_val;
  logic          wrap;
  logic [9*ND-1:0] segment_led;

  segment_counter_multi #(.N_DIGITS(ND), .CNT_NUM(CNT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en(en), .up_dn(up_dn),
    .hex_mode(hex_mode), .clr(clr), .load(load), .load_val(load_val),
    .blank_lz(blank_lz), .count_val(count_val), .wrap(wrap),
    .segment_led(segment_led)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: the count is held as a plain integer in the current base.
  int          m_presc, m_val;
  logic        m_hexq, m_hb, m_wrap;
  logic [17:0] m_seg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [4*ND-1:0] to_digits(input int v, input int base);
    logic [4*ND-1:0] c = '0;
    for (int k = 0; k < ND; k++) c[4*k +: 4] = 4'((v / ipow(base, k)) % base);
    return c;
  endfunction

  function automatic logic [17:0] seg_of(input int v, input int base, input logic hb, input logic bl);
    logic [17:0] s = '0;
    int msd = -1;
    int d;
    for (int k = 0; k < ND; k++) if (((v / ipow(base, k)) % base) != 0) msd = k;
    for (int k = 0; k < ND; k++) begin
      d = (v / ipow(base, k)) % base;
      if (bl && k > msd && k > 0) s[9*k +: 9] = 9'h100;
      else s[9*k +: 9] = {1'b0, (k == 0) ? hb : 1'b0, SEG[d]};
    end
    return s;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_val = 0; m_hexq = 1'b0; m_hb = 1'b0; m_wrap = 1'b0;
    m_seg = {2{9'h03F}};
  endtask

  task automatic model_step();
    int base, m, d;
    logic [17:0] nseg;
    base = m_hexq ? 16 : 10;
    m = ipow(base, ND);
    nseg = seg_of(m_val, base, m_hb, blank_lz);
    m_wrap = 1'b0;
    if (hex_mode != m_hexq) begin
      m_hexq = hex_mode; m_val = 0; m_presc = 0;
    end else if (clr) begin
      m_val = 0; m_presc = 0;
    end else if (load) begin
      m_val = 0;
      for (int k = 0; k < ND; k++) begin
        d = int'(load_val[4*k +: 4]);
        if (d > base - 1) d = base - 1;
        m_val += d * ipow(base, k);
      end
      m_presc = 0;
    end else if (en && m_presc == CNT - 1) begin
      m_presc = 0;
      m_hb = !m_hb;
      if (up_dn) begin
        m_wrap = (m_val == m - 1);
        m_val = (m_val + 1) % m;
      end else begin
        m_wrap = (m_val == 0);
        m_val = (m_val + m - 1) % m;
      end
    end else if (en) begin
      m_presc++;
    end
    m_seg = nseg;
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    chk("mdl_count", 32'(count_val), 32'(to_digits(m_val, m_hexq ? 16 : 10)));
    chk("mdl_wrap", 32'(wrap), 32'(m_wrap));
    chk("mdl_seg", 32'(segment_led), 32'(m_seg));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic        hex;
    logic [7:0]  lv;
    logic        bl;
    logic [7:0]  ec;
    logic [17:0] es;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 8'h3C, 1'b0, 8'h39, {9'h04F, 9'h06F}};
    tbl[1] = '{1'b0, 8'h05, 1'b1, 8'h05, {9'h100, 9'h06D}};
    tbl[2] = '{1'b0, 8'h05, 1'b0, 8'h05, {9'h03F, 9'h06D}};
    tbl[3] = '{1'b1, 8'hAB, 1'b0, 8'hAB, {9'h077, 9'h07C}};
    tbl[4] = '{1'b1, 8'hF0, 1'b1, 8'hF0, {9'h071, 9'h03F}};
    tbl[5] = '{1'b1, 8'h00, 1'b1, 8'h00, {9'h100, 9'h03F}};
    tbl[6] = '{1'b0, 8'h99, 1'b1, 8'h99, {9'h06F, 9'h06F}};
    tbl[7] = '{1'b0, 8'hFF, 1'b0, 8'h99, {9'h06F, 9'h06F}};

    model_reset();
    #23;
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Async reset mid-count
    en = 1'b1;
    cycles(27);
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    chk("rst_count", 32'(count_val), 32'h00);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_seg", 32'(segment_led), 32'(18'h07E3F));
    en = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Decimal up count through 99 and wrap
    en = 1'b1; up_dn = 1'b1; hex_mode = 1'b0;
    cycles(10);
    chk("first_tick", 32'(count_val), 32'h01);
    cycles(98 * CNT);
    chk("at_99", 32'(count_val), 32'h99);
    chk("no_wrap_99", 32'(wrap), 32'h0);
    cycles(CNT);
    chk("wrap_to_00", 32'(count_val), 32'h00);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    cycle();
    chk("wrap_1cyc", 32'(wrap), 32'h0);

    // Hex, down, clear, one tick -> FF with wrap
    hex_mode = 1'b1; up_dn = 1'b0; clr = 1'b1;
    cycles(2);
    clr = 1'b0;
    cycles(CNT);
    chk("hex_dn_ff", 32'(count_val), 32'hFF);
    chk("hex_dn_wrap", 32'(wrap), 32'h1);
    cycle();
    chk("seg_f_lo", 32'(segment_led[8:0] & 9'h17F), 32'h071);
    chk("seg_f_hi", 32'(segment_led[17:9]), 32'h071);

    // Decimal load saturation, clr beats load
    hex_mode = 1'b0;
    cycle();
    load = 1'b1; load_val = 8'h3C;
    cycle();
    chk("load_sat", 32'(count_val), 32'h39);
    clr = 1'b1;
    cycle();
    chk("clr_over_load", 32'(count_val), 32'h00);
    clr = 1'b0; load = 1'b0;

    // Mode toggle at 42: zero, no wrap, prescaler restarts
    load = 1'b1; load_val = 8'h42; up_dn = 1'b1;
    cycle();
    load = 1'b0;
    cycles(4);
    hex_mode = 1'b1;
    cycle();
    chk("mode_zero", 32'(count_val), 32'h00);
    chk("mode_nowrap", 32'(wrap), 32'h0);
    cycles(CNT - 1);
    chk("mode_presc_hold", 32'(count_val), 32'h00);
    cycle();
    chk("mode_presc_tick", 32'(count_val), 32'h01);

    // Paused count holds
    en = 1'b0;
    cycles(3 * CNT);
    chk("pause_hold", 32'(count_val), 32'h01);

    // Constant vectors: load with en=0, check count and display two edges later
    foreach (tbl[i]) begin
      hex_mode = tbl[i].hex;
      cycle();
      load = 1'b1; load_val = tbl[i].lv; blank_lz = tbl[i].bl;
      cycle();
      load = 1'b0;
      cycle();
      chk($sformatf("tbl%0d_count", i), 32'(count_val), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_seg", i), 32'(segment_led & 18'h3FF7F), 32'(tbl[i].es));
    end

    // Randomized run against the model
    blank_lz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 149) == 0);
      load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: load_val = 8'h99;
        1: load_val = 8'hFF;
        2: load_val = 8'h00;
        default: load_val = 8'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 99) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
